// File: rtl/ocimem_pkg.sv
// Shared definitions for the OCI debug-RAM monitor controller: FSM state
// encoding, jdo bit positions and default geometry.
package ocimem_pkg;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned JDO_W       = 38;

  // Field positions inside the captured JTAG word
  localparam int unsigned CLR_ERR_BIT = 35;
  localparam int unsigned CLR_RDY_BIT = 34;
  localparam int unsigned ADDR_LSB    = 26;
  localparam int unsigned WDATA_LSB   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ocimem_timeout_cnt.sv
// Stall counter for the bus request phase.
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear (start of a request)
//   en           : count one stalled cycle
//   tc_c         : count has reached TIMEOUT (combinational)
module ocimem_timeout_cnt #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [CNT_W-1:0] count;

  assign tc_c = (count == CNT_W'(TIMEOUT));

  // Saturates at the terminal count so it can never wrap back under it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ocimem_monitor_ctrl.sv
// Turns debug-slave strobes plus jdo into single-word read/write cycles on
// the on-chip debug RAM port and reports data/ready/error back for scan-out.
//   clk, reset_n              : clock, async active-low reset
//   jdo                       : captured JTAG data word
//   take_action_ocimem_a      : load address / clear flags from jdo
//   take_action_ocimem_b      : write jdo data at current address
//   take_no_action_ocimem_a   : read at current address
//   mem_*                     : debug RAM master port (Avalon-style)
//   MonDReg                   : monitor data register
//   monitor_ready             : last operation complete
//   monitor_error             : sticky timeout / busy-collision flag
module ocimem_monitor_ctrl
  import ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_areg, mon_areg_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic [DATA_W-1:0] mon_dreg_d;
  logic              mem_read_d, mem_write_d, ready_d, error_d;
  logic              idle, do_write, do_read, do_load, busy_err, clr_err;
  logic              tc_c;
  logic              unused_jdo;

  assign unused_jdo    = ^jdo;
  assign mem_writedata = MonDReg;

  // Strobe decode: b > a > no_action; anything outside IDLE is a collision,
  // except an error-clearing address load which is honoured in any state.
  assign idle     = (state_q == IDLE);
  assign do_write = idle && take_action_ocimem_b;
  assign do_load  = idle && take_action_ocimem_a && !take_action_ocimem_b;
  assign do_read  = idle && take_no_action_ocimem_a && !take_action_ocimem_a
                    && !take_action_ocimem_b;
  assign busy_err = !idle && (take_action_ocimem_b || take_no_action_ocimem_a ||
                    (take_action_ocimem_a && !jdo[CLR_ERR_BIT]));
  assign clr_err  = take_action_ocimem_a && jdo[CLR_ERR_BIT] && !take_action_ocimem_b;

  ocimem_timeout_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (do_write || do_read),
    .en      ((state_q == REQ) && mem_waitrequest),
    .tc_c    (tc_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      mon_areg      <= '0;
    end else begin
      state_q       <= state_d;
      mem_read      <= mem_read_d;
      mem_write     <= mem_write_d;
      mem_address   <= mem_address_d;
      MonDReg       <= mon_dreg_d;
      monitor_ready <= ready_d;
      monitor_error <= error_d;
      mon_areg      <= mon_areg_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read;
    mem_write_d   = mem_write;
    mem_address_d = mem_address;
    mon_dreg_d    = MonDReg;
    ready_d       = monitor_ready;
    error_d       = monitor_error;
    mon_areg_d    = mon_areg;

    // Set after clear so a coinciding error event wins
    if (clr_err)  error_d = 1'b0;
    if (busy_err) error_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (do_write) begin
          mon_dreg_d    = jdo[WDATA_LSB +: DATA_W];
          mem_write_d   = 1'b1;
          mem_address_d = mon_areg;
          ready_d       = 1'b0;
          state_d       = REQ;
        end else if (do_load) begin
          mon_areg_d = jdo[ADDR_LSB +: ADDR_W];
          if (jdo[CLR_RDY_BIT]) ready_d = 1'b0;
        end else if (do_read) begin
          mem_read_d    = 1'b1;
          mem_address_d = mon_areg;
          ready_d       = 1'b0;
          state_d       = REQ;
        end
      end
      REQ: begin
        if (!mem_waitrequest) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = mem_read ? RDATA : DONE;
        end else if (tc_c) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          error_d     = 1'b1;
          state_d     = DONE;
        end
      end
      RDATA: begin
        mon_dreg_d = mem_readdata;
        state_d    = DONE;
      end
      DONE: begin
        ready_d    = 1'b1;
        mon_areg_d = mon_areg + ADDR_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ocimem_monitor_ctrl.sv
// Randomised bench for ocimem_monitor_ctrl with a transaction-level model.
module tb_ocimem_monitor_ctrl;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 255;
  localparam int BOUND   = 600;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read, mem_write, mem_waitrequest;
  logic [DATA_W-1:0] mem_writedata, mem_readdata, MonDReg;
  logic              monitor_ready, monitor_error;

  always #5 clk = ~clk;

  ocimem_monitor_ctrl dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .mem_address             (mem_address),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_writedata           (mem_writedata),
    .mem_waitrequest         (mem_waitrequest),
    .mem_readdata            (mem_readdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state
  logic [ADDR_W-1:0] m_areg;
  logic [DATA_W-1:0] m_dreg;
  logic              m_err, m_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_jdo();
    jdo = {6'($urandom), 32'($urandom)};
  endtask

  task automatic model_reset();
    m_areg = '0;
    m_dreg = '0;
    m_err  = 1'b0;
    m_rdy  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},   64'(mem_read), 64'(0));
    check({tag, "_wr"},   64'(mem_write), 64'(0));
    check({tag, "_addr"}, 64'(mem_address), 64'(0));
    check({tag, "_dreg"}, 64'(MonDReg), 64'(0));
    check({tag, "_wd"},   64'(mem_writedata), 64'(0));
    check({tag, "_rdy"},  64'(monitor_ready), 64'(0));
    check({tag, "_err"},  64'(monitor_error), 64'(0));
  endtask

  // Address load / flag clear; never starts a bus cycle
  task automatic do_load(input logic [ADDR_W-1:0] a, input logic ce, input logic cr);
    rand_jdo();
    jdo[35] = ce;
    jdo[34] = cr;
    jdo[33:26] = a;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    m_areg = a;
    if (ce) m_err = 1'b0;
    if (cr) m_rdy = 1'b0;
    check("load_err", 64'(monitor_error), 64'(m_err));
    check("load_rdy", 64'(monitor_ready), 64'(m_rdy));
    check("load_noreq", 64'(mem_read | mem_write), 64'(0));
  endtask

  // One bus transaction with a scripted slave: 'waits' stalled cycles
  // (above TIMEOUT means stuck), optional collision strobe at cycle busy_at,
  // optional lower-priority strobes riding along with a write.
  task automatic do_txn(input bit is_wr, input logic [31:0] data, input int waits,
                        input logic [31:0] rdata, input int busy_at, input bit extra);
    logic [ADDR_W-1:0] exp_addr;
    bit timed_out, acc_prev;
    int exp_req, exp_rdy, req_cnt, addr_bad, kind_bad, rdy_at, kind;
    logic req_at_rdy;
    exp_addr  = m_areg;
    timed_out = (waits > TIMEOUT);
    exp_req   = timed_out ? TIMEOUT + 1 : waits + 1;
    exp_rdy   = timed_out ? TIMEOUT + 3 : waits + (is_wr ? 3 : 4);
    req_cnt = 0; addr_bad = 0; kind_bad = 0; rdy_at = -1; acc_prev = 1'b0;
    req_at_rdy = 1'b0;

    rand_jdo();
    if (is_wr) jdo[34:3] = data;
    take_action_ocimem_b    = is_wr;
    take_no_action_ocimem_a = !is_wr || extra;
    take_action_ocimem_a    = is_wr && extra && ($urandom_range(0, 1) == 1);
    mem_waitrequest = 1'($urandom_range(0, 1));
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;

    for (int c = 1; c < BOUND; c++) begin
      if (monitor_ready) begin
        rdy_at = c;
        req_at_rdy = mem_read | mem_write;
        break;
      end
      mem_readdata = acc_prev ? rdata : 32'($urandom);
      acc_prev = 1'b0;
      if (mem_read | mem_write) begin
        if (mem_address !== exp_addr) addr_bad++;
        if (is_wr && (!mem_write || mem_read || mem_writedata !== data)) kind_bad++;
        if (!is_wr && (!mem_read || mem_write)) kind_bad++;
        mem_waitrequest = (req_cnt < waits);
        if (!mem_waitrequest) acc_prev = 1'b1;
        req_cnt++;
      end else begin
        mem_waitrequest = 1'($urandom_range(0, 1));
      end
      if (c == busy_at) begin
        rand_jdo();
        jdo[35] = 1'b0;
        kind = $urandom_range(0, 2);
        take_action_ocimem_b    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_a    = (kind == 2);
      end
      tick();
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
    end

    if (is_wr) m_dreg = data;
    else if (!timed_out) m_dreg = rdata;
    if (timed_out || busy_at > 0) m_err = 1'b1;
    m_rdy  = 1'b1;
    m_areg = m_areg + 8'd1;

    check("txn_req_cycles", 64'(req_cnt), 64'(exp_req));
    check("txn_addr_bad", 64'(addr_bad), 64'(0));
    check("txn_kind_bad", 64'(kind_bad), 64'(0));
    check("txn_ready_lat", 64'(rdy_at), 64'(exp_rdy));
    check("txn_req_off", 64'(req_at_rdy), 64'(0));
    check("txn_dreg", 64'(MonDReg), 64'(m_dreg));
    check("txn_wdata", 64'(mem_writedata), 64'(m_dreg));
    check("txn_err", 64'(monitor_error), 64'(m_err));
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    mem_waitrequest = 1'b0;
    mem_readdata = '0;
    model_reset();
    tick();
    tick();
    check_reset_outputs("rst0");
    reset_n = 1'b1;
    tick();

    // Address load then zero-wait write
    do_load(8'h10, 1'b0, 1'b0);
    do_txn(1'b1, 32'hDEADBEEF, 0, 32'h0, 0, 1'b0);

    // Read with three wait states at 0x11
    do_txn(1'b0, 32'h0, 3, 32'h12345678, 0, 1'b0);

    // Stuck slave: abort, data kept, sticky error, then cleared
    do_txn(1'b0, 32'h0, 10000, 32'hCAFEF00D, 0, 1'b0);
    do_load(8'h40, 1'b1, 1'b0);

    // Address wrap and collision while busy
    do_load(8'hFF, 1'b0, 1'b1);
    do_txn(1'b0, 32'h0, 1, 32'hA5A5A5A5, 0, 1'b0);
    do_txn(1'b0, 32'h0, 4, 32'h0BADF00D, 2, 1'b0);
    do_load(8'h20, 1'b1, 1'b0);

    // Write with simultaneous lower-priority strobes
    do_txn(1'b1, 32'h13579BDF, 0, 32'h0, 0, 1'b1);

    // Random mix
    for (int i = 0; i < 40; i++) begin
      int w, b;
      bit wr;
      if ($urandom_range(0, 3) == 0)
        do_load(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wr = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 6);
      b  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, w + 2) : 0;
      do_txn(wr, 32'($urandom), w, 32'($urandom), b, wr && ($urandom_range(0, 2) == 0));
    end

    // Reset in the middle of a stalled read
    rand_jdo();
    take_no_action_ocimem_a = 1'b1;
    mem_waitrequest = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    check("midrst_req_before", 64'(mem_read), 64'(1));
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    tick();
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    tick();
    tick();
    check("postrst_noreq", 64'(mem_read | mem_write), 64'(0));
    do_txn(1'b0, 32'h0, 0, 32'h600DCAFE, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
